// File: rtl/ssp_pkg.sv
// Shared SSP definitions: default data width and FIFO depths for the TX and RX
// buffers, plus the helper that sizes an occupancy counter.
package ssp_pkg;

   localparam int SSP_WIDTH    = 8;
   localparam int SSP_TX_DEPTH = 4;
   localparam int SSP_RX_DEPTH = 4;

   // Bits needed to hold an occupancy value in the range 0..depth inclusive.
   function automatic int ssp_count_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/ssp_fifo_ptr.sv
// Circular buffer pointer: advances by one on inc and wraps from DEPTH-1 back
// to 0, so DEPTH need not be a power of two.
module ssp_fifo_ptr
   import ssp_pkg::*;
#(
   parameter int  DEPTH = SSP_TX_DEPTH,
   localparam int PW    = $clog2(DEPTH)
) (
   input  logic          pclk,
   input  logic          clear,
   input  logic          inc,
   output logic [PW-1:0] ptr
);

   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   // Pointer register with explicit wrap at the last storage slot.
   always_ff @(posedge pclk) begin
      if (clear) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
      end
   end

endmodule

// File: rtl/ssp_tx_fifo_param.sv
// SSP transmit FIFO: buffers APB-written words for the transmit logic, with an
// explicit head-valid flag, occupancy status, threshold interrupt and sticky
// overflow/underflow error flags.
module ssp_tx_fifo_param
   import ssp_pkg::*;
#(
   parameter int  WIDTH      = SSP_WIDTH,
   parameter int  DEPTH      = SSP_TX_DEPTH,
   parameter int  INTR_LEVEL = DEPTH,
   localparam int CW         = ssp_count_w(DEPTH)
) (
   input  logic             pclk,
   input  logic             clear,
   input  logic             psel,
   input  logic             pwrite,
   input  logic [WIDTH-1:0] pwdata,
   input  logic             remove,
   input  logic             clear_err,
   output logic [WIDTH-1:0] txdata,
   output logic             tmit,
   output logic             ssptxintr,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count,
   output logic             overflow,
   output logic             underflow
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count_q;

   logic push_req;
   logic pop_acc;
   logic push_acc;
   logic ovf_evt;
   logic unf_evt;

   // A pop frees a slot in the same cycle, so a full FIFO still accepts a
   // push when the head is leaving. A pop on empty never sees the incoming
   // word: there is no write-through.
   assign push_req = psel & pwrite;
   assign pop_acc  = remove & ~empty;
   assign push_acc = push_req & (~full | pop_acc);
   assign ovf_evt  = push_req & full & ~pop_acc;
   assign unf_evt  = remove & empty;

   ssp_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
      .pclk  (pclk),
      .clear (clear),
      .inc   (push_acc),
      .ptr   (wr_ptr)
   );

   ssp_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
      .pclk  (pclk),
      .clear (clear),
      .inc   (pop_acc),
      .ptr   (rd_ptr)
   );

   // Storage write; contents are not reset, validity is tracked by count.
   always_ff @(posedge pclk) begin
      if (push_acc && !clear) begin
         mem[wr_ptr] <= pwdata;
      end
   end

   // Occupancy: changes only when exactly one of push/pop is accepted.
   always_ff @(posedge pclk) begin
      if (clear) begin
         count_q <= '0;
      end else begin
         case ({push_acc, pop_acc})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Sticky error flags; a new event in the same cycle beats clear_err.
   always_ff @(posedge pclk) begin
      if (clear) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (ovf_evt) begin
            overflow <= 1'b1;
         end else if (clear_err) begin
            overflow <= 1'b0;
         end
         if (unf_evt) begin
            underflow <= 1'b1;
         end else if (clear_err) begin
            underflow <= 1'b0;
         end
      end
   end

   // Status is decoded from the registered count only, so none of it depends
   // combinationally on the request inputs.
   assign count     = count_q;
   assign full      = (count_q == CW'(DEPTH));
   assign empty     = (count_q == '0);
   assign tmit      = ~empty;
   assign ssptxintr = (count_q >= CW'(INTR_LEVEL));
   assign txdata    = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_ssp_tx_fifo_param.sv
// Bench for ssp_tx_fifo_param: two instances (DEPTH=4/INTR_LEVEL=4 and
// DEPTH=5/INTR_LEVEL=2) share one stimulus stream and are each compared every
// cycle against a queue-based model, plus directed expectations.
module tb_ssp_tx_fifo_param;

   logic       pclk = 1'b0;
   logic       clear = 1'b0;
   logic       psel = 1'b0;
   logic       pwrite = 1'b0;
   logic [7:0] pwdata = 8'h00;
   logic       remove = 1'b0;
   logic       clear_err = 1'b0;

   logic [7:0] txdata_a, txdata_b;
   logic       tmit_a, tmit_b, intr_a, intr_b, full_a, full_b, empty_a, empty_b;
   logic [2:0] count_a, count_b;
   logic       ovf_a, ovf_b, unf_a, unf_b;

   int checks = 0;
   int failures = 0;

   // Model state, index 0 = DUT a, index 1 = DUT b.
   logic [7:0] mq [2][$];
   int         mdepth [2] = '{4, 5};
   int         mlevel [2] = '{4, 2};
   logic       movf [2];
   logic       munf [2];

   always #5 pclk = ~pclk;

   ssp_tx_fifo_param #(.WIDTH(8), .DEPTH(4), .INTR_LEVEL(4)) dut_a (
      .pclk(pclk), .clear(clear), .psel(psel), .pwrite(pwrite), .pwdata(pwdata),
      .remove(remove), .clear_err(clear_err), .txdata(txdata_a), .tmit(tmit_a),
      .ssptxintr(intr_a), .full(full_a), .empty(empty_a), .count(count_a),
      .overflow(ovf_a), .underflow(unf_a));

   ssp_tx_fifo_param #(.WIDTH(8), .DEPTH(5), .INTR_LEVEL(2)) dut_b (
      .pclk(pclk), .clear(clear), .psel(psel), .pwrite(pwrite), .pwdata(pwdata),
      .remove(remove), .clear_err(clear_err), .txdata(txdata_b), .tmit(tmit_b),
      .ssptxintr(intr_b), .full(full_b), .empty(empty_b), .count(count_b),
      .overflow(ovf_b), .underflow(unf_b));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply the FIFO rules to one model for the inputs seen at this edge.
   task automatic model_step(input int m);
      int  sz;
      bit  preq, pop, push;
      sz = mq[m].size();
      if (clear) begin
         mq[m].delete();
         movf[m] = 1'b0;
         munf[m] = 1'b0;
      end else begin
         preq = psel && pwrite;
         pop  = remove && (sz > 0);
         push = preq && ((sz < mdepth[m]) || pop);
         if (preq && (sz == mdepth[m]) && !pop) movf[m] = 1'b1;
         else if (clear_err)                   movf[m] = 1'b0;
         if (remove && (sz == 0))              munf[m] = 1'b1;
         else if (clear_err)                   munf[m] = 1'b0;
         if (pop)  void'(mq[m].pop_front());
         if (push) mq[m].push_back(pwdata);
      end
   endtask

   task automatic compare(input int m, input logic [7:0] td, input logic tm, input logic it,
                          input logic fu, input logic em, input logic [2:0] cn,
                          input logic ov, input logic un);
      int  sz;
      string p;
      sz = mq[m].size();
      p  = (m == 0) ? "a" : "b";
      check({p, ".count"},     32'(cn), 32'(sz));
      check({p, ".tmit"},      32'(tm), 32'(sz != 0));
      check({p, ".empty"},     32'(em), 32'(sz == 0));
      check({p, ".full"},      32'(fu), 32'(sz == mdepth[m]));
      check({p, ".ssptxintr"}, 32'(it), 32'(sz >= mlevel[m]));
      check({p, ".txdata"},    32'(td), (sz == 0) ? 32'h0 : 32'(mq[m][0]));
      check({p, ".overflow"},  32'(ov), 32'(movf[m]));
      check({p, ".underflow"}, 32'(un), 32'(munf[m]));
   endtask

   // One clock: drive inputs, step both models at the edge, sample #1 later.
   task automatic drive(input logic ps, input logic pw, input logic [7:0] d,
                        input logic r, input logic ce, input logic cl);
      psel = ps; pwrite = pw; pwdata = d; remove = r; clear_err = ce; clear = cl;
      @(posedge pclk);
      model_step(0);
      model_step(1);
      #1;
      compare(0, txdata_a, tmit_a, intr_a, full_a, empty_a, count_a, ovf_a, unf_a);
      compare(1, txdata_b, tmit_b, intr_b, full_b, empty_b, count_b, ovf_b, unf_b);
   endtask

   task automatic push(input logic [7:0] d); drive(1, 1, d, 0, 0, 0); endtask
   task automatic pop();                     drive(0, 0, 8'h00, 1, 0, 0); endtask
   task automatic idle();                    drive(0, 0, 8'h00, 0, 0, 0); endtask
   task automatic reset();                   drive(0, 0, 8'h00, 0, 0, 1); endtask

   initial begin
      logic [7:0] exp_seq [4];
      movf = '{1'b0, 1'b0};
      munf = '{1'b0, 1'b0};

      // Reset state
      reset();
      check("rst.tmit", 32'(tmit_a), 32'h0);
      check("rst.empty", 32'(empty_a), 32'h1);
      check("rst.txdata", 32'(txdata_a), 32'h0);

      // Zero-valued word is still flagged valid
      push(8'h00);
      check("zero.tmit", 32'(tmit_a), 32'h1);
      check("zero.txdata", 32'(txdata_a), 32'h00);
      push(8'h11);
      check("two.count", 32'(count_a), 32'h2);
      check("two.empty", 32'(empty_a), 32'h0);

      // Fill, overflow, drain in order
      reset();
      push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
      check("fill.full", 32'(full_a), 32'h1);
      check("fill.intr", 32'(intr_a), 32'h1);
      check("fill.count", 32'(count_a), 32'h4);
      push(8'hA5);
      check("ovf.flag", 32'(ovf_a), 32'h1);
      check("ovf.count", 32'(count_a), 32'h4);
      exp_seq = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
      for (int i = 0; i < 4; i++) begin
         check($sformatf("drain.%0d", i), 32'(txdata_a), 32'(exp_seq[i]));
         pop();
      end
      check("drain.empty", 32'(empty_a), 32'h1);
      check("drain.txdata", 32'(txdata_a), 32'h0);

      // Push and pop together while full
      reset();
      push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
      drive(1, 1, 8'hB5, 1, 0, 0);
      check("fullpp.count", 32'(count_a), 32'h4);
      check("fullpp.ovf", 32'(ovf_a), 32'h0);
      exp_seq = '{8'hA2, 8'hA3, 8'hA4, 8'hB5};
      for (int i = 0; i < 4; i++) begin
         check($sformatf("wrap.%0d", i), 32'(txdata_a), 32'(exp_seq[i]));
         pop();
      end

      // Underflow, clear_err, pop-on-empty with push
      reset();
      pop();
      check("unf.set", 32'(unf_a), 32'h1);
      drive(0, 0, 8'h00, 0, 1, 0);
      check("unf.clr", 32'(unf_a), 32'h0);
      drive(1, 1, 8'h3C, 1, 0, 0);
      check("unf.pp", 32'(unf_a), 32'h1);
      check("unf.count", 32'(count_a), 32'h1);
      check("unf.txdata", 32'(txdata_a), 32'h3C);
      // set beats clear_err in the same cycle
      reset();
      drive(0, 0, 8'h00, 1, 1, 0);
      check("unf.setwins", 32'(unf_a), 32'h1);

      // Threshold and non-power-of-2 wrap on the DEPTH=5 instance
      reset();
      push(8'h01);
      check("lvl.one", 32'(intr_b), 32'h0);
      push(8'h02);
      check("lvl.two", 32'(intr_b), 32'h1);
      for (int i = 0; i < 12; i++) drive(1, 1, 8'(8'h40 + i), 1, 0, 0);
      check("wrap5.head", 32'(txdata_b), 32'h4A);

      // Clear overrides push/pop and sticky flags
      reset();
      pop();
      push(8'h21); push(8'h22); push(8'h23);
      drive(1, 1, 8'h24, 1, 0, 1);
      check("clr.count", 32'(count_a), 32'h0);
      check("clr.tmit", 32'(tmit_a), 32'h0);
      check("clr.full", 32'(full_a), 32'h0);
      check("clr.unf", 32'(unf_a), 32'h0);
      check("clr.ovf", 32'(ovf_a), 32'h0);

      // Randomized traffic against the models
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 8'($urandom),
               1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0),
               1'($urandom_range(0, 63) == 0));
      end
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
